// File: rtl/morse_lcd_pkg.sv
// morse_lcd_pkg: shared definitions for the LCD write path of the Morse system.
// Holds the arbiter state encoding and the field widths of one LCD character write.
package morse_lcd_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int LCD_ROW_W  = 2;
    localparam int LCD_COL_W  = 4;
    localparam int LCD_CHAR_W = 8;

    // A space character, so an unwritten latch shows nothing on the display
    localparam logic [LCD_CHAR_W-1:0] LCD_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_DONE = ST_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first valid index strictly after last_grant, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam int DBL_W = 2 * NUM_REQ;

    logic [DBL_W-1:0] w_doubled;
    logic [DBL_W-1:0] w_mask;
    logic [DBL_W-1:0] w_candidates;
    logic             w_found;

    // The upper copy of valid supplies the wrap-around; the mask drops everything up to last_grant
    always_comb begin
        w_doubled    = {valid, valid};
        w_mask       = ~((DBL_W'(1) << (32'(last_grant) + 1)) - DBL_W'(1));
        w_candidates = w_doubled & w_mask;
    end

    // Lowest surviving bit wins; positions in the upper copy fold back onto the real index
    always_comb begin
        w_found = 1'b0;
        idx     = '0;
        for (int p = 0; p < DBL_W; p++) begin
            if (!w_found && w_candidates[p]) begin
                w_found = 1'b1;
                idx     = (p >= NUM_REQ) ? IDX_W'(p - NUM_REQ) : IDX_W'(p);
            end
        end
        any    = w_found;
        onehot = w_found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares the single LCD controller write port between NUM_REQ writers.
// One write is in flight at a time; completion or a watchdog abort is routed to the owner.
module lcd_write_arbiter
    import morse_lcd_pkg::*;
#(
    parameter int NUM_REQ             = 3,
    parameter int DONE_TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [LCD_ROW_W*NUM_REQ-1:0]  req_row,
    input  logic [LCD_COL_W*NUM_REQ-1:0]  req_col,
    input  logic [LCD_CHAR_W*NUM_REQ-1:0] req_char,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic                          lcd_req,
    output logic [LCD_ROW_W-1:0]          lcd_row,
    output logic [LCD_COL_W-1:0]          lcd_col,
    output logic [LCD_CHAR_W-1:0]         lcd_char,
    input  logic                          lcd_busy,
    input  logic                          lcd_done,
    output logic                          arb_busy,
    output logic                          timeout_flag
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DONE_TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DONE_TIMEOUT_CYCLES - 1);

    arb_state_t r_state;
    arb_state_t w_nextState;

    logic [IDX_W-1:0]      r_lastGrant;
    logic [IDX_W-1:0]      r_owner;
    logic [LCD_ROW_W-1:0]  r_row;
    logic [LCD_COL_W-1:0]  r_col;
    logic [LCD_CHAR_W-1:0] r_char;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_REQ-1:0]    r_reqDone;
    logic [NUM_REQ-1:0]    r_reqErr;
    logic                  r_timeoutFlag;

    logic [NUM_REQ-1:0] w_pickOnehot;
    logic [IDX_W-1:0]   w_pickIdx;
    logic               w_pickAny;
    logic               w_grant;
    logic               w_doneHit;
    logic               w_timeoutHit;
    logic [NUM_REQ-1:0] w_ownerOnehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rrPick (
        .valid      (req_valid),
        .last_grant (r_lastGrant),
        .onehot     (w_pickOnehot),
        .idx        (w_pickIdx),
        .any        (w_pickAny)
    );

    // Next-state and per-cycle events; lcd_done is checked before the terminal count so it wins a tie
    always_comb begin
        w_nextState  = r_state;
        w_grant      = 1'b0;
        w_doneHit    = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pickAny && !lcd_busy) begin
                    w_grant     = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_nextState = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (lcd_done) begin
                    w_doneHit   = 1'b1;
                    w_nextState = IDLE;
                end else if (r_count == CNT_TERMINAL) begin
                    w_timeoutHit = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture the winner's fields at acceptance so later changes by the writer cannot disturb the write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_char  <= LCD_BLANK;
        end else if (w_grant) begin
            r_owner <= w_pickIdx;
            r_row   <= req_row[int'(w_pickIdx)*LCD_ROW_W +: LCD_ROW_W];
            r_col   <= req_col[int'(w_pickIdx)*LCD_COL_W +: LCD_COL_W];
            r_char  <= req_char[int'(w_pickIdx)*LCD_CHAR_W +: LCD_CHAR_W];
        end
    end

    // Watchdog: restarts with every strobe and stops at the terminal count rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == ISSUE) begin
            r_count <= '0;
        end else if (r_state == WAIT_DONE && !w_doneHit && !w_timeoutHit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Completion bookkeeping: one-cycle owner pulses, sticky timeout flag, round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reqDone     <= '0;
            r_reqErr      <= '0;
            r_timeoutFlag <= 1'b0;
            r_lastGrant   <= IDX_LAST;
        end else begin
            r_reqDone <= w_doneHit ? w_ownerOnehot : '0;
            r_reqErr  <= w_timeoutHit ? w_ownerOnehot : '0;
            if (w_timeoutHit) begin
                r_timeoutFlag <= 1'b1;
            end
            if (w_doneHit || w_timeoutHit) begin
                r_lastGrant <= r_owner;
            end
        end
    end

    assign w_ownerOnehot = NUM_REQ'(1) << r_owner;
    assign req_ready     = w_grant ? w_pickOnehot : '0;
    assign req_done      = r_reqDone;
    assign req_err       = r_reqErr;
    assign lcd_req       = (r_state == ISSUE);
    assign lcd_row       = r_row;
    assign lcd_col       = r_col;
    assign lcd_char      = r_char;
    assign arb_busy      = (r_state != IDLE);
    assign timeout_flag  = r_timeoutFlag;

endmodule
